count_event_fifo: RTL and testbench
===================================

// Module: count_event_fifo
// PURPOSE
//  Downstream consumer of the 8-bit free-running counter output. Samples the count
//  every clk and detects three events: wrap (FF->00), clear (drop to 00 other than a wrap),
//  and threshold hit. Each event is queued as a timestamped record in a small FIFO.
//  A valid/ready port drains the FIFO to a logger or monitor stage.
// PARAMETERS
//  THRESHOLD  8'h80  count value that raises a THRESH event on entry
//  DEPTH      4      FIFO entries; power of two, >=2
//  TS_W       16     timestamp width in clk cycles
// PORTS
//  clk        in   1     rising-edge clock
//  reset      in   1     asynchronous, active-low reset
//  value      in   8     count from upstream counter, sampled every clk
//  ev_valid   out  1     FIFO head record available
//  ev_ready   in   1     consumer accepts head when ev_valid && ev_ready at clk edge
//  ev_type    out  2     01=WRAP 10=CLEAR 11=THRESH (00 never output while valid)
//  ev_value   out  8     count value that triggered the event
//  ev_time    out  TS_W  timestamp at push
//  overflow   out  1     sticky: an event was dropped because the FIFO was full
//  drop_cnt   out  8     dropped events, saturates at 8'hFF
//  clear_ovf  in   1     one-cycle pulse; clears overflow and drop_cnt
// BEHAVIOUR
//  Reset (reset=0, async): ev_valid=0, ev_type=0, ev_value=0, ev_time=0, overflow=0,
//   drop_cnt=0, FIFO empty, ts=0, prev_ok=0. The outputs hold these values until release.
//  ts: a TS_W counter that increments every clk after release and wraps at 2^TS_W-1 -> 0.
//  Sampling: val_q<=value each edge. prev_ok<=1 at the first edge after release.
//   No detection happens while prev_ok=0, so the first post-reset sample never yields an event.
//  Detection at edge E compares value with val_q. At most one event per edge, priority:
//   WRAP   : val_q==8'hFF && value==8'h00
//   CLEAR  : value==8'h00 && val_q!=8'h00 && val_q!=8'hFF
//   THRESH : value==THRESHOLD && val_q!=THRESHOLD
//   A lower-priority match in the same edge is discarded and is not counted as a drop.
//  Push: the record {type,value,ts} is written at edge E. ev_valid=1 after E, so latency is 1 edge.
//   Head outputs are registered (first-word fall-through) and stay stable while ev_valid && !ev_ready.
//  Pop: ev_valid && ev_ready at an edge removes the head. The next record appears after that edge.
//  Simultaneous push and pop: both occur. When full, the push is accepted because a slot frees.
//  Full, push, no pop: the event is dropped. overflow<=1 and drop_cnt<=sat(drop_cnt+1).
//  clear_ovf coincident with a drop: the clear applies first, giving overflow=1, drop_cnt=1.
//  Empty with ev_ready=1: no effect. ev_* head fields hold their last values.
//  Pointers are log2(DEPTH)+1 bits and wrap naturally; full and empty are derived from the MSB.
//  Reset asserted mid-operation: the FIFO is flushed immediately and all records are lost.
//  Records are never reordered; output order is the detection order.
// TESTING
//  1 Reset 0..20 cycles, value steady 8'h05 -> ev_valid stays 0, overflow=0, drop_cnt=0.
//  2 value steps 8'h7F->8'h80, ev_ready=1 -> one record THRESH(11), ev_value=8'h80,
//    ev_time=ts at push. ev_valid high 1 cycle after the step.
//  3 value 8'hFE,8'hFF,8'h00 -> WRAP(01), ev_value=00. Then 8'h10->8'h00 -> CLEAR(10).
//  4 THRESHOLD=0, value FF->00 -> a single WRAP record, no THRESH, drop_cnt unchanged.
//  5 ev_ready=0, generate 6 events with DEPTH=4 -> 4 records held, overflow=1,
//    drop_cnt=2. Drain -> records in order. clear_ovf -> overflow=0, drop_cnt=0.
//  6 FIFO full, event with ev_ready=1 on the same edge -> no drop, count stays 4.
//    Then reset=0 mid-stream -> ev_valid=0 immediately (async).

Source files
------------

// File: rtl/count_event_fifo.sv
// -----------------------------------------------------------------------------
// count_event_fifo
//
// Watches the 8-bit count of an upstream free-running counter, samples it every
// clock and detects three events against the previous sample:
//   WRAP   (FF -> 00)
//   CLEAR  (drop to 00 from anything other than FF or 00)
//   THRESH (entry into THRESHOLD)
// At most one event per edge is recognised, in that priority order. Each event
// is pushed as a {type, value, timestamp} record into a DEPTH-entry FIFO that is
// drained through a valid/ready port. Events that find the FIFO full (with no
// pop on the same edge) are dropped and counted.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; flushes the FIFO
//   value      count from the upstream counter, sampled every clk
//   ev_valid   head record available
//   ev_ready   consumer accepts the head when ev_valid && ev_ready at an edge
//   ev_type    01=WRAP 10=CLEAR 11=THRESH
//   ev_value   count value that triggered the event
//   ev_time    timestamp (ts counter value at the pushing edge)
//   overflow   sticky: an event was dropped because the FIFO was full
//   drop_cnt   number of dropped events, saturating at 8'hFF
//   clear_ovf  one-cycle pulse clearing overflow and drop_cnt
// -----------------------------------------------------------------------------
module count_event_fifo #(
    parameter logic [7:0] THRESHOLD = 8'h80,
    parameter int         DEPTH     = 4,
    parameter int         TS_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      value,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [1:0]      ev_type,
    output logic [7:0]      ev_value,
    output logic [TS_W-1:0] ev_time,
    output logic            overflow,
    output logic [7:0]      drop_cnt,
    input  logic            clear_ovf
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        EV_NONE   = 2'b00,
        EV_WRAP   = 2'b01,
        EV_CLEAR  = 2'b10,
        EV_THRESH = 2'b11
    } ev_kind_t;

    typedef struct packed {
        ev_kind_t        kind;
        logic [7:0]      val;
        logic [TS_W-1:0] ts;
    } record_t;

    logic [TS_W-1:0] ts;
    logic [7:0]      val_q;
    logic            prev_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic            empty, full;

    record_t         mem [DEPTH];
    record_t         head_q, head_nxt, push_rec;

    ev_kind_t        det;
    logic            push, pop, accept, drop;

    // ---------------------------------------------------------------- detect
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        det = EV_NONE;
        if (prev_ok) begin
            if (val_q == 8'hFF && value == 8'h00)
                det = EV_WRAP;
            else if (value == 8'h00 && val_q != 8'h00)
                det = EV_CLEAR;   // val_q==FF already taken by WRAP above
            else if (value == THRESHOLD && val_q != THRESHOLD)
                det = EV_THRESH;
        end
    end

    assign push     = (det != EV_NONE);
    assign push_rec = '{kind: det, val: value, ts: ts};

    // ------------------------------------------------------------ fifo status
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && ev_ready;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign wr_nxt = wr_ptr + {{AW{1'b0}}, accept};
    assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};

    // The head register is reloaded with whatever record will sit at rd_nxt.
    // When that slot is the one being written this edge, bypass the memory.
    always_comb begin
        head_nxt = head_q;
        if (wr_nxt != rd_nxt) begin
            if (accept && rd_nxt == wr_ptr)
                head_nxt = push_rec;
            else
                head_nxt = mem[rd_nxt[AW-1:0]];
        end
    end

    // ------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts       <= '0;
            val_q    <= '0;
            prev_ok  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_q   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ts      <= ts + 1'b1;
            val_q   <= value;
            prev_ok <= 1'b1;
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            head_q  <= head_nxt;
            // A clear coinciding with a drop is applied first.
            if (clear_ovf) begin
                overflow <= drop;
                drop_cnt <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr[AW-1:0]] <= push_rec;
    end

    // --------------------------------------------------------------- outputs
    assign ev_valid = !empty;
    assign ev_type  = head_q.kind;
    assign ev_value = head_q.val;
    assign ev_time  = head_q.ts;

endmodule

// File: tb/tb_count_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_count_event_fifo
//
// Directed bench for count_event_fifo. A second instance with THRESHOLD=0
// shares clock, reset and value to show that WRAP shadows a coincident THRESH.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_count_event_fifo;

    localparam int TS_W = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      value;
    logic            ev_ready;
    logic            clear_ovf;

    logic            ev_valid,  ev_valid1;
    logic [1:0]      ev_type,   ev_type1;
    logic [7:0]      ev_value,  ev_value1;
    logic [TS_W-1:0] ev_time,   ev_time1;
    logic            overflow,  overflow1;
    logic [7:0]      drop_cnt,  drop_cnt1;

    int errors = 0;
    int checks = 0;

    int ts_now  = 0;   // DUT ts register value before the next edge
    int last_ts = 0;   // ts value at the most recent edge

    logic [1:0]  exp_type [4];
    logic [7:0]  exp_val  [4];
    int          exp_ts   [4];

    always #5 clk = ~clk;

    count_event_fifo #(.THRESHOLD(8'h80), .DEPTH(4), .TS_W(TS_W)) dut (
        .clk(clk), .reset(reset), .value(value),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
        .ev_value(ev_value), .ev_time(ev_time), .overflow(overflow),
        .drop_cnt(drop_cnt), .clear_ovf(clear_ovf)
    );

    count_event_fifo #(.THRESHOLD(8'h00), .DEPTH(4), .TS_W(TS_W)) dut_t0 (
        .clk(clk), .reset(reset), .value(value),
        .ev_valid(ev_valid1), .ev_ready(1'b1), .ev_type(ev_type1),
        .ev_value(ev_value1), .ev_time(ev_time1), .overflow(overflow1),
        .drop_cnt(drop_cnt1), .clear_ovf(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive value, let the edge happen, settle.
    task automatic tick(input logic [7:0] v);
        value   = v;
        last_ts = ts_now;
        @(posedge clk);
        #1;
        ts_now++;
    endtask

    task automatic check_head(input string tag, input logic [1:0] t,
                              input logic [7:0] v, input int ts);
        check({tag, "_valid"}, ev_valid, 1'b1);
        check({tag, "_type"},  ev_type,  t);
        check({tag, "_value"}, ev_value, v);
        check({tag, "_time"},  ev_time,  ts[TS_W-1:0]);
    endtask

    initial begin
        int n;

        // ---------------- 1: reset held, value steady
        reset = 1'b0; value = 8'h05; ev_ready = 1'b0; clear_ovf = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("rst_mid_valid", ev_valid, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("rst_valid", ev_valid, 1'b0);
        check("rst_ovf",   overflow, 1'b0);
        check("rst_drop",  drop_cnt, 8'd0);
        check("rst_type",  ev_type,  2'd0);
        check("rst_time",  ev_time,  16'd0);
        reset  = 1'b1;
        ts_now = 0;
        repeat (3) tick(8'h05);
        check("steady_valid", ev_valid, 1'b0);

        // ---------------- 2: threshold entry
        ev_ready = 1'b1;
        tick(8'h7F);
        check("pre_thr_valid", ev_valid, 1'b0);
        tick(8'h80);
        check_head("thr", 2'b11, 8'h80, last_ts);
        check("thr_t0_none", ev_valid1, 1'b0);
        tick(8'h80);
        check("thr_popped", ev_valid, 1'b0);

        // ---------------- 3: wrap, then clear (and 4: WRAP beats THRESH=0)
        tick(8'hFE);
        tick(8'hFF);
        check("pre_wrap_valid", ev_valid, 1'b0);
        tick(8'h00);
        check_head("wrap", 2'b01, 8'h00, last_ts);
        check("t0_wrap_type",  ev_type1,  2'b01);
        check("t0_wrap_value", ev_value1, 8'h00);
        check("t0_drop",       drop_cnt1, 8'd0);
        tick(8'h10);
        check("wrap_popped", ev_valid, 1'b0);
        check("t0_wrap_popped", ev_valid1, 1'b0);
        tick(8'h00);
        check_head("clear", 2'b10, 8'h00, last_ts);
        tick(8'h00);
        check("clear_popped", ev_valid, 1'b0);

        // ---------------- 5: overflow with ev_ready low, then drain
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_type[i] = (i % 2 == 0) ? 2'b11 : 2'b10;
            exp_val[i]  = (i % 2 == 0) ? 8'h80 : 8'h00;
            tick(exp_val[i]);
            exp_ts[i] = last_ts;
        end
        check_head("full_head", exp_type[0], exp_val[0], exp_ts[0]);
        check("full_ovf", overflow, 1'b0);
        tick(8'h80);
        tick(8'h00);
        check("ovf_set",  overflow, 1'b1);
        check("ovf_drop", drop_cnt, 8'd2);
        check_head("held_head", exp_type[0], exp_val[0], exp_ts[0]);

        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), exp_type[i], exp_val[i], exp_ts[i]);
            tick(8'h00);
        end
        check("drained_valid", ev_valid, 1'b0);
        tick(8'h00);
        check("empty_hold_type",  ev_type,  exp_type[3]);
        check("empty_hold_value", ev_value, exp_val[3]);
        check("empty_hold_time",  ev_time,  exp_ts[3][TS_W-1:0]);

        clear_ovf = 1'b1;
        tick(8'h00);
        clear_ovf = 1'b0;
        check("clr_ovf",  overflow, 1'b0);
        check("clr_drop", drop_cnt, 8'd0);

        // ---------------- 6: full + simultaneous push/pop, clear-with-drop
        ev_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            tick((i % 2 == 0) ? 8'h80 : 8'h00);
        clear_ovf = 1'b1;
        tick(8'h80);                 // dropped on the clearing edge
        clear_ovf = 1'b0;
        check("clr_drop_ovf", overflow, 1'b1);
        check("clr_drop_cnt", drop_cnt, 8'd1);

        ev_ready = 1'b1;
        tick(8'h00);                 // CLEAR pushed while full, head popped
        check("pushpop_drop", drop_cnt, 8'd1);
        n = 0;
        for (int k = 0; k < 10 && ev_valid; k++) begin
            n++;
            tick(8'h00);
        end
        check("pushpop_count", n, 4);
        check("pushpop_last_type", ev_type, 2'b10);

        ev_ready = 1'b0;
        tick(8'h80);
        check("pre_async_valid", ev_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_valid", ev_valid, 1'b0);
        check("async_ovf",   overflow, 1'b0);
        check("async_drop",  drop_cnt, 8'd0);
        check("async_type",  ev_type,  2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
